// File: rtl/dv_cam_pkg.sv
// Shared camera-path definitions: capture FSM states, default frame geometry
// and the pixel width used by the capture block and its consumers.
package dv_cam_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int PIX_W        = 16;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_VS_HIGH = 3'd1,
    WAIT_VS_LOW  = 3'd2,
    CAPTURE      = 3'd3,
    DONE         = 3'd4
  } cap_state_e;

  // Decimation is 1 or 2, so the per-axis divide is a right shift by 0 or 1.
  function automatic int decim_shift(input int decim);
    return (decim >= 2) ? 1 : 0;
  endfunction

endpackage

// File: rtl/fb_port_arb.sv
// Registered single-port framebuffer mux. Capture writes always win; a
// pending read is issued only on cycles with no write.
//
// Read handshake: rd_req is a level the reader holds until it sees rd_grant.
// rd_grant=1 means rd_addr (sampled on the previous edge) is on fb_addr this
// cycle; read data is valid one cycle after rd_grant. The reader drops or
// changes rd_req/rd_addr only after a grant.
module fb_port_arb #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              rd_grant
);

  logic              fb_we_q, fb_we_d;
  logic              rd_grant_q, rd_grant_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0] fb_wdata_q, fb_wdata_d;

  // Port selection: write beats read; idle cycles hold the last address.
  always_comb begin
    fb_we_d    = 1'b0;
    rd_grant_d = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    if (wr_en) begin
      fb_we_d    = 1'b1;
      fb_addr_d  = wr_addr;
      fb_wdata_d = wr_data;
    end else if (rd_req) begin
      rd_grant_d = 1'b1;
      fb_addr_d  = rd_addr;
    end
  end

  // Output register for the framebuffer port.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we_q    <= 1'b0;
      rd_grant_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      fb_we_q    <= fb_we_d;
      rd_grant_q <= rd_grant_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
    end
  end

  assign fb_we    = fb_we_q;
  assign rd_grant = rd_grant_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms on cap_start / cap_continuous, aligns to the
// next full frame via vsync, decimates and writes pixels into the framebuffer
// and shares the framebuffer port with a downstream reader.
// Optional build macro CAP_TIMEOUT_EN adds a watchdog that aborts a capture
// stuck in any armed state for TIMEOUT_CYCLES cycles.
module frame_capture_ctrl
  import dv_cam_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEF,
  parameter int V_ACTIVE       = V_ACTIVE_DEF,
  parameter int DECIM          = 2,
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              p_clock,
  input  logic              rst,
  input  logic              vsync,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic [9:0]        pix_x,
  input  logic [8:0]        pix_y,
  input  logic              pix_valid,
  input  logic              frame_done,
  input  logic              cap_start,
  input  logic              cap_continuous,
  output logic              cap_busy,
  output logic              cap_done,
  output logic [7:0]        frame_count,
  output logic              cap_timeout,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_wdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant
);

  // Elaboration-time guards on the configuration.
  if (!(DECIM == 1 || DECIM == 2)) begin : g_bad_decim
    $error("frame_capture_ctrl: DECIM must be 1 or 2");
  end
  if ((64'd1 << ADDR_W) < 64'((H_ACTIVE / DECIM) * (V_ACTIVE / DECIM))) begin : g_bad_addr_w
    $error("frame_capture_ctrl: ADDR_W too small for the decimated frame");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 4194303) begin : g_bad_timeout
    $error("frame_capture_ctrl: TIMEOUT_CYCLES must fit the 22-bit watchdog");
  end

  localparam int         DSH    = decim_shift(DECIM);
  localparam int         LINE_W = H_ACTIVE / DECIM;
  localparam logic [9:0] XMASK  = 10'(DECIM - 1);
  localparam logic [8:0] YMASK  = 9'(DECIM - 1);

  cap_state_e        state_q, state_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              capture_en;
  logic              timeout_hit;
  logic              wr_cand;
  logic [ADDR_W-1:0] wr_addr;

  // Current FSM state, visible to checkers by hierarchical reference.
  cap_state_e        state_dbg;
  assign state_dbg = state_q;

  // State register and completed-frame counter.
  always_ff @(posedge p_clock) begin
    if (rst) begin
      state_q       <= IDLE;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next state: vsync must rise then fall before capture, so a capture
  // requested mid-frame waits for the following frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (cap_start || cap_continuous) state_d = WAIT_VS_HIGH;
      WAIT_VS_HIGH: if (vsync)      state_d = WAIT_VS_LOW;
      WAIT_VS_LOW:  if (!vsync)     state_d = CAPTURE;
      CAPTURE:      if (frame_done) state_d = DONE;
      DONE:         state_d = cap_continuous ? WAIT_VS_HIGH : IDLE;
      default:      state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  // Moore outputs and the frame counter update (wraps 255 -> 0).
  always_comb begin
    cap_busy      = (state_q != IDLE);
    cap_done      = (state_q == DONE);
    capture_en    = (state_q == CAPTURE);
    frame_count_d = frame_count_q + ((state_q == DONE) ? 8'd1 : 8'd0);
  end

  // Write candidate (in-range, on the decimation grid) and its raster address.
  always_comb begin
    wr_cand = capture_en && pix_valid
           && (32'(pix_x) < 32'(H_ACTIVE)) && (32'(pix_y) < 32'(V_ACTIVE))
           && ((pix_x & XMASK) == 10'd0) && ((pix_y & YMASK) == 9'd0);
    wr_addr = ADDR_W'(((32'(pix_y) >> DSH) * 32'(LINE_W)) + (32'(pix_x) >> DSH));
  end

`ifdef CAP_TIMEOUT_EN
  localparam logic [21:0] TMO_LAST = 22'(TIMEOUT_CYCLES - 1);

  logic [21:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_pulse_q, tmo_pulse_d;
  logic        tmo_counting;

  // Watchdog: restarts on every state change, runs only while armed.
  always_comb begin
    tmo_counting = (state_q == WAIT_VS_HIGH) || (state_q == WAIT_VS_LOW) ||
                   (state_q == CAPTURE);
    timeout_hit  = tmo_counting && (tmo_cnt_q == TMO_LAST);
    tmo_pulse_d  = timeout_hit;
    if (!tmo_counting || (state_d != state_q)) tmo_cnt_d = '0;
    else                                       tmo_cnt_d = tmo_cnt_q + 22'd1;
  end

  // Watchdog counter and one-cycle timeout pulse.
  always_ff @(posedge p_clock) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign cap_timeout = tmo_pulse_q;
`else
  assign timeout_hit = 1'b0;
  assign cap_timeout = 1'b0;
`endif

  assign frame_count = frame_count_q;

  fb_port_arb #(
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_arb (
    .clk      (p_clock),
    .rst      (rst),
    .wr_en    (wr_cand),
    .wr_addr  (wr_addr),
    .wr_data  (pix_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .rd_grant (rd_grant)
  );

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl on a reduced 16x8 frame with 2x
// decimation (8x4 = 32 framebuffer words).
module tb_frame_capture_ctrl;
  import dv_cam_pkg::*;

  localparam int H   = 16;
  localparam int V   = 8;
  localparam int D   = 2;
  localparam int AW  = 6;
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              vsync;
  logic [15:0]       pix_data;
  logic [9:0]        pix_x;
  logic [8:0]        pix_y;
  logic              pix_valid;
  logic              frame_done;
  logic              cap_start;
  logic              cap_continuous;
  logic              cap_busy;
  logic              cap_done;
  logic [7:0]        frame_count;
  logic              cap_timeout;
  logic              fb_we;
  logic [AW-1:0]     fb_addr;
  logic [15:0]       fb_wdata;
  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic              rd_grant;

  frame_capture_ctrl #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .DECIM          (D),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .p_clock        (clk),
    .rst            (rst),
    .vsync          (vsync),
    .pix_data       (pix_data),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_valid      (pix_valid),
    .frame_done     (frame_done),
    .cap_start      (cap_start),
    .cap_continuous (cap_continuous),
    .cap_busy       (cap_busy),
    .cap_done       (cap_done),
    .frame_count    (frame_count),
    .cap_timeout    (cap_timeout),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_wdata       (fb_wdata),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_grant       (rd_grant)
  );

  // ---------------- scoreboard ----------------
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] wr_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_low_cnt = 0;

  // Observed port writes and status pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (fb_we === 1'b1) wr_q.push_back({fb_addr, fb_wdata});
    if (cap_done === 1'b1) done_cnt++;
    if (cap_busy !== 1'b1) busy_low_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    pix_valid  = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic drive_pixel(input int x, input int y, input logic valid, input logic done);
    pix_x      = 10'(x);
    pix_y      = 9'(y);
    pix_data   = 16'(y * 256 + x);
    pix_valid  = valid;
    frame_done = done;
    tick();
  endtask

  // vsync blanking, then a w x h raster, then frame_done (optionally on the
  // last pixel), then two idle cycles.
  task automatic send_frame(input int w, input int h, input bit done_on_last);
    idle_bus();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        drive_pixel(x, y, 1'b1, done_on_last && (x == w - 1) && (y == h - 1));
    idle_bus();
    if (!done_on_last) begin
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
    end
    repeat (2) tick();
  endtask

  // Expected writes for a w x h raster: in range, on the 2x grid, raster order.
  task automatic build_exp(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (x < H && y < V && (x % D) == 0 && (y % D) == 0)
          exp_q.push_back({AW'((y / D) * (H / D) + x / D), 16'(y * 256 + x)});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", cap_busy); end
    checks++; if (cap_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", cap_done); end
    checks++; if (cap_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b exp 0", cap_timeout); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", fb_we); end
    checks++; if (rd_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got %0b exp 0", rd_grant); end
    checks++; if (fb_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d exp 0", fb_addr); end
    checks++; if (fb_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %0h exp 0", fb_wdata); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", frame_count); end
    rst = 1'b0;
    tick();
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", cap_busy); end
  endtask

  // One frame including out-of-range columns 16,17 and row 8.
  task automatic test_single_frame();
    int base_w, base_d;
    base_w = wr_q.size();
    base_d = done_cnt;
    exp_q.delete();
    build_exp(H + 2, V + 1);
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    checks++; if (cap_busy !== 1'b1) begin errors++; $display("FAIL single_armed_busy got %0b exp 1", cap_busy); end
    send_frame(H + 2, V + 1, 1'b0);
    checks++;
    if (wr_q.size() - base_w !== exp_q.size()) begin
      errors++; $display("FAIL single_write_count got %0d exp %0d", wr_q.size() - base_w, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_q[base_w + i] !== exp_q[i]) begin
          errors++; $display("FAIL single_write[%0d] got %h exp %h", i, wr_q[base_w + i], exp_q[i]);
        end
      end
      checks++;
      if (wr_q[base_w + 9] !== {AW'(9), 16'h0202}) begin
        errors++; $display("FAIL single_pixel_2_2 got %h exp addr 9 data 0202", wr_q[base_w + 9]);
      end
      checks++;
      if (wr_q[wr_q.size() - 1][AW+15:16] !== AW'(31)) begin
        errors++; $display("FAIL single_last_addr got %0d exp 31", wr_q[wr_q.size() - 1][AW+15:16]);
      end
    end
    checks++; if (done_cnt - base_d !== 1) begin errors++; $display("FAIL single_done_pulses got %0d exp 1", done_cnt - base_d); end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", frame_count); end
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %0b exp 0", cap_busy); end
  endtask

  // cap_start while a frame is already streaming; frame_done on last pixel.
  task automatic test_mid_frame_start();
    int base_w, base_d;
    base_w = wr_q.size();
    base_d = done_cnt;
    vsync = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cap_start = (i == 5);
      drive_pixel(i % H, i / H, 1'b1, 1'b0);
    end
    cap_start = 1'b0;
    idle_bus();
    tick();
    checks++; if (wr_q.size() !== base_w) begin errors++; $display("FAIL midframe_no_write got %0d exp 0", wr_q.size() - base_w); end
    checks++; if (cap_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %0b exp 1", cap_busy); end
    exp_q.delete();
    build_exp(H - 1, V - 1);
    send_frame(H - 1, V - 1, 1'b1);
    checks++;
    if (wr_q.size() - base_w !== exp_q.size()) begin
      errors++; $display("FAIL midframe_write_count got %0d exp %0d", wr_q.size() - base_w, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_q[base_w + i] !== exp_q[i]) begin
          errors++; $display("FAIL midframe_write[%0d] got %h exp %h", i, wr_q[base_w + i], exp_q[i]);
        end
      end
    end
    checks++; if (done_cnt - base_d !== 1) begin errors++; $display("FAIL midframe_done_pulses got %0d exp 1", done_cnt - base_d); end
    checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL midframe_count got %0d exp 2", frame_count); end
  endtask

  // Three back-to-back frames in continuous mode.
  task automatic test_continuous();
    int base_w, base_d, base_b;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    cap_continuous = 1'b1;
    tick();
    base_w = wr_q.size();
    base_d = done_cnt;
    base_b = busy_low_cnt;
    for (int f = 0; f < 3; f++) begin
      build_exp(H, V);
      send_frame(H, V, 1'b0);
    end
    checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL cont_count got %0d exp 3", frame_count); end
    checks++; if (done_cnt - base_d !== 3) begin errors++; $display("FAIL cont_done_pulses got %0d exp 3", done_cnt - base_d); end
    checks++; if (busy_low_cnt - base_b !== 0) begin errors++; $display("FAIL cont_busy_drop got %0d cycles exp 0", busy_low_cnt - base_b); end
    checks++;
    if (wr_q.size() - base_w !== exp_q.size()) begin
      errors++; $display("FAIL cont_write_count got %0d exp %0d", wr_q.size() - base_w, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_q[base_w + i] !== exp_q[i]) begin
          errors++; $display("FAIL cont_write[%0d] got %h exp %h", i, wr_q[base_w + i], exp_q[i]);
        end
      end
    end
    cap_continuous = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Reads in IDLE, then reads interleaved with writes during CAPTURE.
  task automatic test_read_arb();
    logic exp_we;
    rd_req  = 1'b1;
    rd_addr = AW'(5);
    tick();
    checks++; if (rd_grant !== 1'b1) begin errors++; $display("FAIL idle_rd_grant got %0b exp 1", rd_grant); end
    checks++; if (fb_addr !== AW'(5)) begin errors++; $display("FAIL idle_rd_addr got %0d exp 5", fb_addr); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL idle_rd_we got %0b exp 0", fb_we); end
    rd_req = 1'b0;
    tick();
    checks++; if (rd_grant !== 1'b0) begin errors++; $display("FAIL idle_rd_release got %0b exp 0", rd_grant); end
    checks++; if (fb_addr !== AW'(5)) begin errors++; $display("FAIL idle_addr_hold got %0d exp 5", fb_addr); end
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    rd_req  = 1'b1;
    rd_addr = AW'(50);
    for (int x = 0; x < 8; x++) begin
      drive_pixel(x, 0, 1'b1, 1'b0);
      exp_we = ((x % 2) == 0);
      checks++; if (fb_we !== exp_we) begin errors++; $display("FAIL arb_we x=%0d got %0b exp %0b", x, fb_we, exp_we); end
      checks++; if (rd_grant !== !exp_we) begin errors++; $display("FAIL arb_grant x=%0d got %0b exp %0b", x, rd_grant, !exp_we); end
      checks++;
      if (fb_addr !== (exp_we ? AW'(x / 2) : AW'(50))) begin
        errors++; $display("FAIL arb_addr x=%0d got %0d exp %0d", x, fb_addr, exp_we ? x / 2 : 50);
      end
    end
    rd_req = 1'b0;
    idle_bus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Reset asserted while a write candidate is present in CAPTURE.
  task automatic test_reset_mid_capture();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    send_frame(H, V, 1'b0);
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL rstcap_pre_count got %0d exp 1", frame_count); end
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    drive_pixel(0, 0, 1'b1, 1'b0);
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL rstcap_pre_we got %0b exp 1", fb_we); end
    rst = 1'b1;
    drive_pixel(2, 0, 1'b1, 1'b0);
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rstcap_we got %0b exp 0", fb_we); end
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL rstcap_busy got %0b exp 0", cap_busy); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL rstcap_count got %0d exp 0", frame_count); end
    rst = 1'b0;
    drive_pixel(4, 0, 1'b1, 1'b0);
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rstcap_post_we got %0b exp 0", fb_we); end
    idle_bus();
    tick();
  endtask

`ifdef CAP_TIMEOUT_EN
  // vsync stuck low after arming: watchdog fires after TMO cycles armed.
  task automatic test_timeout();
    int n;
    int base_d;
    logic [7:0] fc;
    base_d = done_cnt;
    fc     = frame_count;
    n      = 0;
    vsync  = 1'b0;
    idle_bus();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    while (cap_timeout !== 1'b1 && n < 2 * TMO) begin
      tick();
      n++;
    end
    checks++; if (n !== TMO) begin errors++; $display("FAIL timeout_cycle got %0d exp %0d", n, TMO); end
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %0b exp 0", cap_busy); end
    checks++; if (frame_count !== fc) begin errors++; $display("FAIL timeout_count got %0d exp %0d", frame_count, fc); end
    checks++; if (done_cnt !== base_d) begin errors++; $display("FAIL timeout_done got %0d exp %0d", done_cnt - base_d, 0); end
    tick();
    checks++; if (cap_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width got %0b exp 0", cap_timeout); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst            = 1'b1;
    vsync          = 1'b0;
    pix_data       = '0;
    pix_x          = '0;
    pix_y          = '0;
    pix_valid      = 1'b0;
    frame_done     = 1'b0;
    cap_start      = 1'b0;
    cap_continuous = 1'b0;
    rd_req         = 1'b0;
    rd_addr        = '0;
    test_reset();
    test_single_frame();
    test_mid_frame_start();
    test_continuous();
    test_read_arb();
    test_reset_mid_capture();
`ifdef CAP_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences single-shot or continuous capture of camera frames into the on-chip framebuffer.
- Consumes the decoded pixel stream (16-bit pixel, X/Y index, valid, frame_done) from the camera capture block and aligns capture to frame boundaries via vsync.
- Optionally decimates the frame, generates framebuffer write addresses, and arbitrates the single framebuffer port between capture writes and a downstream reader (detection engine).

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- DECIM, 2, decimation factor in both axes; legal values 1 or 2.
- ADDR_W, 17, framebuffer address width; must satisfy 2^ADDR_W >= (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM).
- TIMEOUT_CYCLES, 2000000, watchdog limit; used only with CAP_TIMEOUT_EN.

Ports:
- p_clock  in  1  pixel clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- vsync  in  1  camera vsync; high = vertical blanking.
- pix_data  in  16  pixel from the capture block.
- pix_x  in  10  pixel column.
- pix_y  in  9  pixel row.
- pix_valid  in  1  pixel qualifier.
- frame_done  in  1  end-of-frame pulse from the capture block.
- cap_start  in  1  one-cycle pulse requesting one frame.
- cap_continuous  in  1  level; while high, re-arm after every frame.
- cap_busy  out  1  high from arm until DONE.
- cap_done  out  1  one-cycle pulse per completed frame.
- frame_count  out  8  count of completed frames.
- cap_timeout  out  1  watchdog pulse (0 when feature is off).
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  ADDR_W  framebuffer address (write or read).
- fb_wdata  out  16  framebuffer write data.
- rd_req  in  1  reader request; held until granted.
- rd_addr  in  ADDR_W  reader address.
- rd_grant  out  1  read issued on fb_addr this cycle; data valid one cycle later.

Behaviour:
- Reset (rst=1 at a p_clock edge): state IDLE. cap_busy, cap_done, cap_timeout, fb_we, rd_grant, fb_addr, fb_wdata and frame_count all 0. Reset overrides every other input.
- FSM states and transitions:
  - IDLE: on cap_start or cap_continuous -> WAIT_VS_HIGH. cap_busy=0.
  - WAIT_VS_HIGH: on vsync=1 -> WAIT_VS_LOW. This guarantees capture never starts mid-frame.
  - WAIT_VS_LOW: on vsync=0 -> CAPTURE.
  - CAPTURE: on frame_done -> DONE. Writes are enabled only in this state.
  - DONE: single cycle. Asserts cap_done, and frame_count increments (255 wraps to 0). If cap_continuous=1 -> WAIT_VS_HIGH, else -> IDLE.
- cap_busy=1 in every state except IDLE. cap_start while busy is ignored (no queueing).
- Write candidate, evaluated in CAPTURE: pix_valid && pix_x<H_ACTIVE && pix_y<V_ACTIVE && pix_x%DECIM==0 && pix_y%DECIM==0.
  - Out-of-range indices (e.g. x=640, y=480) are never written.
- Write address = (pix_y/DECIM)*(H_ACTIVE/DECIM) + pix_x/DECIM, truncated to ADDR_W bits.
  - DECIM is a power of two, so the divides are shifts; the multiply is by a constant.
- Port outputs are registered, giving one cycle of latency from candidate to fb_we/fb_addr/fb_wdata.
- Port arbitration, decided each cycle:
  - A write candidate wins: fb_we=1, rd_grant=0.
  - Otherwise, if rd_req: fb_addr<=rd_addr, rd_grant=1, fb_we=0.
  - Otherwise fb_we=0, rd_grant=0, fb_addr holds its value.
- Reads are permitted in every state, including CAPTURE.
- A pixel and frame_done in the same cycle: the pixel is written if it is a candidate, then the FSM goes to DONE.
- Reset mid-capture: no write is issued on the cycle after reset. Framebuffer contents are undefined.

Optional Feature:
- Macro: CAP_TIMEOUT_EN.
- When defined: a 22-bit counter clears on entry to WAIT_VS_HIGH and on every FSM transition, and counts while in WAIT_VS_HIGH, WAIT_VS_LOW or CAPTURE. On reaching TIMEOUT_CYCLES: cap_timeout pulses for one cycle, the FSM goes to IDLE, cap_done stays 0, and frame_count is unchanged.
- When undefined: no counter is built and cap_timeout is tied to 0.

Decomposition:
- Package dv_cam_pkg holds:
  - the state enum (IDLE, WAIT_VS_HIGH, WAIT_VS_LOW, CAPTURE, DONE);
  - the H_ACTIVE/V_ACTIVE defaults and the pixel width constant (16), shared with the capture block.
- Sub-module fb_port_arb: the registered write/read mux and grant logic. The FSM and address generation stay in the top module.

Test Plan:
- Mini frame (H_ACTIVE=8, V_ACTIVE=4, DECIM=1), cap_start, one full frame -> 32 writes at addr 0..31 in raster order, one cap_done pulse, frame_count=1, cap_busy=0 afterwards.
- Default parameters, one frame -> 76800 writes; pixel (2,2) writes addr 321; pixels (3,2) and (2,3) produce no write; last write addr 76799.
- Stimulus pixels with x=640 or y=480 and pix_valid=1 during CAPTURE -> no fb_we.
- cap_start mid-frame (vsync=0, pixels flowing) -> zero writes until vsync has gone high then low; cap_continuous=1 for 3 frames -> frame_count=3, cap_busy held high throughout.
- rd_req held during CAPTURE with a write candidate every other cycle -> rd_grant only on non-write cycles with fb_addr=rd_addr; rd_req in IDLE -> rd_grant one cycle later.
- rst asserted mid-CAPTURE -> next cycle fb_we=0, cap_busy=0, frame_count=0. With CAP_TIMEOUT_EN and TIMEOUT_CYCLES=100, vsync stuck low -> cap_timeout pulses at cycle 100 and the FSM returns to IDLE.
